// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC generator and PC register for the 8-bit MIPS core.
// Ports:
//   clk, rst          - clock; synchronous active-high reset
//   fetch_ready       - instruction memory accepts pc_out this cycle
//   stall             - pipeline hazard, blocks sequential advance
//   branch_taken      - taken-branch redirect, target = pc_plus1 + signed branch_offset
//   jump, jump_target - absolute redirect (wins over branch)
//   halt, resume      - enter / leave the HALT state
//   pc_out            - registered current PC (feeds program_counter pc_ip)
//   pc_plus1          - combinational pc_out + INCR
//   pc_valid          - pc_out is a valid fetch address
//   halted            - high while in HALT
//   redirect_pending  - a redirect is latched awaiting resume
module pc_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [7:0] INCR     = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fetch_ready,
  input  logic       stall,
  input  logic       branch_taken,
  input  logic [7:0] branch_offset,
  input  logic       jump,
  input  logic [7:0] jump_target,
  input  logic       halt,
  input  logic       resume,
  output logic [7:0] pc_out,
  output logic [7:0] pc_plus1,
  output logic       pc_valid,
  output logic       halted,
  output logic       redirect_pending
);

  localparam int unsigned PC_W = 8;

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_d;
  logic            valid_d;
  logic            halted_d;
  logic            pending_d;
  logic [PC_W-1:0] pend_q, pend_d;
  logic [PC_W-1:0] branch_target;
  logic            redirect_req;
  logic [PC_W-1:0] redirect_target;

  // Link/branch base; wraps silently at 8 bits.
  assign pc_plus1 = PC_W'(pc_out + INCR);

  // Two's-complement add gives the signed-offset target modulo 256.
  assign branch_target   = PC_W'(pc_plus1 + branch_offset);
  assign redirect_req    = jump | branch_taken;
  assign redirect_target = jump ? jump_target : branch_target;

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_out;
    valid_d   = pc_valid;
    halted_d  = halted;
    pending_d = redirect_pending;
    pend_d    = pend_q;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        valid_d = 1'b1;
      end
      RUN: begin
        if (halt) begin
          state_d  = HALT;
          halted_d = 1'b1;
          valid_d  = 1'b0;
          if (redirect_req) begin
            pend_d    = redirect_target;
            pending_d = 1'b1;
          end
        end else if (redirect_req) begin
          pc_d = redirect_target;
        end else if (pc_valid && fetch_ready && !stall) begin
          pc_d = pc_plus1;
        end
      end
      HALT: begin
        valid_d = 1'b0;
        if (resume && !halt) begin
          state_d  = RUN;
          halted_d = 1'b0;
          valid_d  = 1'b1;
          // A redirect arriving with resume supersedes the latched one.
          if (redirect_req) begin
            pc_d      = redirect_target;
            pending_d = 1'b0;
          end else if (redirect_pending) begin
            pc_d      = pend_q;
            pending_d = 1'b0;
          end
        end else if (redirect_req) begin
          pend_d    = redirect_target;
          pending_d = 1'b1;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= BOOT;
      pc_out           <= RESET_PC;
      pc_valid         <= 1'b0;
      halted           <= 1'b0;
      redirect_pending <= 1'b0;
      pend_q           <= '0;
    end else begin
      state_q          <= state_d;
      pc_out           <= pc_d;
      pc_valid         <= valid_d;
      halted           <= halted_d;
      redirect_pending <= pending_d;
      pend_q           <= pend_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven and randomized self-checking bench for pc_sequencer.
module tb_pc_sequencer;

  localparam logic [7:0] RST_PC = 8'h10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fetch_ready = 1'b0;
  logic       stall = 1'b0;
  logic       branch_taken = 1'b0;
  logic [7:0] branch_offset = 8'h00;
  logic       jump = 1'b0;
  logic [7:0] jump_target = 8'h00;
  logic       halt = 1'b0;
  logic       resume = 1'b0;
  logic [7:0] pc_out;
  logic [7:0] pc_plus1;
  logic       pc_valid;
  logic       halted;
  logic       redirect_pending;

  int errors = 0;
  int checks = 0;

  pc_sequencer #(.RESET_PC(RST_PC), .INCR(8'h01)) dut (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_target(jump_target), .halt(halt), .resume(resume),
    .pc_out(pc_out), .pc_plus1(pc_plus1), .pc_valid(pc_valid),
    .halted(halted), .redirect_pending(redirect_pending)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst, fr, st, br;
    logic [7:0] off;
    logic       jmp;
    logic [7:0] tgt;
    logic       hlt, res;
    logic [7:0] e_pc;
    logic       e_v, e_h, e_rp;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic f, input logic s, input logic b,
                              input logic [7:0] o, input logic j, input logic [7:0] t,
                              input logic h, input logic rs, input logic [7:0] epc,
                              input logic ev, input logic eh, input logic erp);
    vec_t v;
    v.rst = r; v.fr = f; v.st = s; v.br = b; v.off = o; v.jmp = j; v.tgt = t;
    v.hlt = h; v.res = rs; v.e_pc = epc; v.e_v = ev; v.e_h = eh; v.e_rp = erp;
    return v;
  endfunction

  // Behavioural reference: flags describe the machine, not an encoded state.
  int m_pc = 0;
  bit m_valid = 0, m_halted = 0, m_booting = 1, m_has_pend = 0;
  int m_pend = 0;

  task automatic model_step(input vec_t v);
    int red;
    red = -1;
    if (v.jmp) red = int'(v.tgt);
    else if (v.br) red = (m_pc + 1 + int'($signed(v.off))) & 255;
    if (v.rst) begin
      m_pc = int'(RST_PC); m_valid = 0; m_halted = 0; m_booting = 1;
      m_has_pend = 0; m_pend = 0;
    end else if (m_booting) begin
      m_booting = 0; m_valid = 1;
    end else if (!m_halted) begin
      if (v.hlt) begin
        m_halted = 1; m_valid = 0;
        if (red >= 0) begin m_pend = red; m_has_pend = 1; end
      end else if (red >= 0) m_pc = red;
      else if (m_valid && v.fr && !v.st) m_pc = (m_pc + 1) & 255;
    end else begin
      if (v.res && !v.hlt) begin
        m_halted = 0; m_valid = 1;
        if (red >= 0) begin m_pc = red; m_has_pend = 0; end
        else if (m_has_pend) begin m_pc = m_pend; m_has_pend = 0; end
      end else if (red >= 0) begin
        m_pend = red; m_has_pend = 1;
      end
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drive one cycle, then compare against table values or the model.
  task automatic apply(input vec_t v, input bit use_model, input string tag);
    int epc, ev, eh, erp;
    @(negedge clk);
    rst = v.rst; fetch_ready = v.fr; stall = v.st; branch_taken = v.br;
    branch_offset = v.off; jump = v.jmp; jump_target = v.tgt;
    halt = v.hlt; resume = v.res;
    @(posedge clk);
    model_step(v);
    #1;
    if (use_model) begin
      epc = m_pc; ev = int'(m_valid); eh = int'(m_halted); erp = int'(m_has_pend);
    end else begin
      epc = int'(v.e_pc); ev = int'(v.e_v); eh = int'(v.e_h); erp = int'(v.e_rp);
    end
    chk({tag, ".pc_out"}, int'(pc_out), epc);
    chk({tag, ".pc_plus1"}, int'(pc_plus1), (epc + 1) & 255);
    chk({tag, ".pc_valid"}, int'(pc_valid), ev);
    chk({tag, ".halted"}, int'(halted), eh);
    chk({tag, ".redirect_pending"}, int'(redirect_pending), erp);
  endtask

  vec_t tbl[$];
  vec_t rv;

  initial begin
    // rst fr st br off  jmp tgt  hlt res | pc  v  h  rp
    tbl.push_back(mk(1,1,0,0,8'h00,0,8'h00,0,0, 8'h10,0,0,0)); // reset
    tbl.push_back(mk(1,1,0,0,8'h00,0,8'h00,0,0, 8'h10,0,0,0));
    tbl.push_back(mk(0,1,0,0,8'h00,0,8'h00,0,0, 8'h10,1,0,0)); // boot -> run
    tbl.push_back(mk(0,1,0,0,8'h00,0,8'h00,0,0, 8'h11,1,0,0));
    tbl.push_back(mk(0,1,0,0,8'h00,0,8'h00,0,0, 8'h12,1,0,0));
    tbl.push_back(mk(0,1,0,0,8'h00,0,8'h00,0,0, 8'h13,1,0,0));
    tbl.push_back(mk(0,1,0,0,8'h00,1,8'hFE,0,0, 8'hFE,1,0,0)); // back-pressure + wrap
    tbl.push_back(mk(0,1,0,0,8'h00,0,8'h00,0,0, 8'hFF,1,0,0));
    tbl.push_back(mk(0,0,0,0,8'h00,0,8'h00,0,0, 8'hFF,1,0,0));
    tbl.push_back(mk(0,1,0,0,8'h00,0,8'h00,0,0, 8'h00,1,0,0));
    tbl.push_back(mk(0,1,1,0,8'h00,0,8'h00,0,0, 8'h00,1,0,0));
    tbl.push_back(mk(0,1,1,0,8'h00,0,8'h00,0,0, 8'h00,1,0,0));
    tbl.push_back(mk(0,1,1,0,8'h00,0,8'h00,0,0, 8'h00,1,0,0));
    tbl.push_back(mk(0,1,0,0,8'h00,1,8'h20,0,0, 8'h20,1,0,0)); // redirects
    tbl.push_back(mk(0,1,0,1,8'hF0,0,8'h00,0,0, 8'h11,1,0,0));
    tbl.push_back(mk(0,0,1,1,8'h05,1,8'h80,0,0, 8'h80,1,0,0));
    tbl.push_back(mk(0,1,0,0,8'h00,1,8'h40,0,0, 8'h40,1,0,0)); // halt + pending
    tbl.push_back(mk(0,1,0,0,8'h00,0,8'h00,1,0, 8'h40,0,1,0));
    tbl.push_back(mk(0,1,0,0,8'h00,1,8'h60,0,0, 8'h40,0,1,1));
    tbl.push_back(mk(0,1,0,0,8'h00,1,8'h70,0,0, 8'h40,0,1,1));
    tbl.push_back(mk(0,0,0,0,8'h00,0,8'h00,0,1, 8'h70,1,0,0));
    tbl.push_back(mk(0,1,0,0,8'h00,0,8'h00,0,0, 8'h71,1,0,0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 1'b0, $sformatf("tbl%0d", i));

    // Halt and branch together in RUN, then resume.
    apply(mk(0,1,0,0,8'h00,1,8'h05,0,0, 8'h05,1,0,0), 1'b0, "s5a");
    apply(mk(0,1,0,1,8'h02,0,8'h00,1,0, 8'h05,0,1,1), 1'b0, "s5b");
    apply(mk(0,1,0,0,8'h00,0,8'h00,0,1, 8'h08,1,0,0), 1'b0, "s5c");
    // Resume ignored in RUN; halt+resume stays halted; resume with new jump wins.
    apply(mk(0,0,0,0,8'h00,0,8'h00,0,1, 8'h08,1,0,0), 1'b0, "s7a");
    apply(mk(0,1,0,0,8'h00,0,8'h00,1,0, 8'h08,0,1,0), 1'b0, "s7b");
    apply(mk(0,1,0,0,8'h00,0,8'h00,1,1, 8'h08,0,1,0), 1'b0, "s7c");
    apply(mk(0,1,0,0,8'h00,1,8'h50,0,0, 8'h08,0,1,1), 1'b0, "s7d");
    apply(mk(0,1,0,0,8'h00,1,8'h33,0,1, 8'h33,1,0,0), 1'b0, "s7e");
    // Reset while halted with a pending redirect.
    apply(mk(0,1,0,0,8'h00,0,8'h00,1,0, 8'h33,0,1,0), 1'b0, "s6a");
    apply(mk(0,1,0,1,8'h00,0,8'h00,0,0, 8'h33,0,1,1), 1'b0, "s6b");
    apply(mk(1,1,0,0,8'h00,0,8'h00,0,0, 8'h10,0,0,0), 1'b0, "s6c");
    apply(mk(0,1,0,0,8'h00,1,8'h99,0,0, 8'h10,1,0,0), 1'b0, "s6d");
    apply(mk(0,1,0,0,8'h00,0,8'h00,0,0, 8'h11,1,0,0), 1'b0, "s6e");
    apply(mk(0,1,0,0,8'h00,0,8'h00,1,0, 8'h11,0,1,0), 1'b0, "s6f");
    apply(mk(0,1,0,0,8'h00,0,8'h00,0,1, 8'h11,1,0,0), 1'b0, "s6g");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      rv = mk(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
              8'($urandom), ($urandom_range(0, 9) == 0), 8'($urandom),
              ($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0),
              8'h00, 1'b0, 1'b0, 1'b0);
      apply(rv, 1'b1, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
